// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared state type, segment table and width helper for the BCD counter display
package bcd_disp_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high patterns {g,f,e,d,c,b,a}, entry 0 first
    localparam logic [0:9][6:0] SEG_PAT = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Register width for a counter holding 0..value-1, never below one bit
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/bcd_counter_scan_disp_seg7_decode.sv
// seg7_decode: BCD digit to active-high seven-segment pattern
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Codes above 9 never leave the counter; they show blank
    always_comb seg = (bcd <= 4'd9) ? SEG_PAT[bcd] : SEG_BLANK;

endmodule

// File: rtl/bcd_counter_scan_disp.sv
// bcd_counter_scan_disp: N-digit BCD up/down event counter with multiplexed seven-segment scan
module bcd_counter_scan_disp
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 1000,
    parameter int SCAN_DIV    = 256,
    parameter int WRAP_EN     = 1,
    parameter int SEG_ACT_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cnt_start,
    input  logic                    cnt_stop,
    input  logic                    cnt_rst,
    input  logic                    cnt_dir,
    output logic [4*NUM_DIGITS-1:0] cnt_bcd,
    output logic                    running,
    output logic                    wrap_o,
    output logic [6:0]              disp_seg,
    output logic [NUM_DIGITS-1:0]   disp_dig,
    output logic [6+NUM_DIGITS:0]   out_en
);

    localparam int PW = clog2(TICK_DIV);
    localparam int SW = clog2(SCAN_DIV);
    localparam int IW = clog2(NUM_DIGITS);
    localparam int CW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
    localparam logic POL  = (SEG_ACT_LOW != 0);
    localparam logic WRAP = (WRAP_EN != 0);

    logic [3:0]    pad;
    logic [2:0]    rise;
    logic          dir;
    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [CW-1:0] cnt_q, cnt_d, step;
    logic          carry, tick, wrap_d;
    logic [SW-1:0] sc_q;
    logic [IW-1:0] idx_q;
    logic [3:0]    dsel;
    logic [NUM_DIGITS-1:0] dig_oh;
    logic [6:0]    seg_raw;

    // Pad order: start, stop, clear edges on bits 0..2, direction level on bit 3
    assign pad = {cnt_dir, cnt_rst, cnt_stop, cnt_start};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        logic [1:0] s;
        // two-flop synchroniser against pad metastability
        always_ff @(posedge clk) begin
            if (!rst_n) s <= '0;
            else        s <= {s[0], pad[i]};
        end
        if (i < 3) begin : g_edge
            logic h;
            // history flop so each pad press acts once on its rising edge
            always_ff @(posedge clk) begin
                if (!rst_n) h <= 1'b0;
                else        h <= s[1];
            end
            assign rise[i] = s[1] & ~h;
        end else begin : g_lvl
            assign dir = s[1];
        end
    end

    // Ripple carry (up) or borrow (down) across digits; a carry out of the top digit marks terminal count
    always_comb begin
        step  = cnt_q;
        carry = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                step[4*d +: 4] = dir ? ((cnt_q[4*d +: 4] == 4'd0) ? 4'd9 : cnt_q[4*d +: 4] - 4'd1)
                                     : ((cnt_q[4*d +: 4] == 4'd9) ? 4'd0 : cnt_q[4*d +: 4] + 4'd1);
                carry = dir ? (cnt_q[4*d +: 4] == 4'd0) : (cnt_q[4*d +: 4] == 4'd9);
            end
        end
    end

    // Next state, prescaler and count: stop beats start, clear beats a coincident tick
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        tick    = (state_q == RUN) && (pre_q == PRE_MAX);
        if (state_q == RUN) pre_d = tick ? '0 : pre_q + 1'b1;
        if (rise[1]) state_d = STOP;
        else if (rise[0] && state_q == STOP) begin
            state_d = RUN;
            pre_d   = '0;
        end
        if (rise[2]) begin
            cnt_d = '0;
            pre_d = '0;
        end else if (tick) begin
            wrap_d = carry;
            cnt_d  = (carry && !WRAP) ? cnt_q : step;
            if (carry && !WRAP) state_d = STOP;
        end
    end

    // State, prescaler, count and rollover pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STOP;
            pre_q   <= '0;
            cnt_q   <= '0;
            wrap_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            wrap_o  <= wrap_d;
        end
    end

    assign cnt_bcd = cnt_q;
    assign running = (state_q == RUN);
    assign out_en  = '0;

    // Scan timer dwells SCAN_DIV cycles per digit, then advances the digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc_q  <= '0;
            idx_q <= '0;
        end else begin
            sc_q <= (sc_q == SCAN_MAX) ? '0 : sc_q + 1'b1;
            if (sc_q == SCAN_MAX) idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    // Pick the indexed digit and build its one-hot enable
    always_comb begin
        dsel   = '0;
        dig_oh = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            dig_oh[d] = (idx_q == IW'(d));
            if (idx_q == IW'(d)) dsel = cnt_q[4*d +: 4];
        end
    end

    seg7_decode u_dec (
        .bcd (dsel),
        .seg (seg_raw)
    );

    // Registered display drive with pad polarity applied
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_seg <= SEG_BLANK ^ {7{POL}};
            disp_dig <= {NUM_DIGITS{POL}};
        end else begin
            disp_seg <= seg_raw ^ {7{POL}};
            disp_dig <= dig_oh ^ {NUM_DIGITS{POL}};
        end
    end

endmodule

// File: tb/tb_bcd_counter_scan_disp.sv
// tb_bcd_counter_scan_disp: three configurations driven in parallel and compared to an integer reference model
module tb_bcd_counter_scan_disp;

    localparam int NC = 3;
    localparam int WRAPS [NC] = '{1, 0, 1};
    localparam int LOWS  [NC] = '{0, 0, 1};

    logic clk = 1'b0;
    logic rst_n, cnt_start, cnt_stop, cnt_rst, cnt_dir;
    logic [7:0] o_cnt  [NC];
    logic       o_run  [NC];
    logic       o_wrap [NC];
    logic [6:0] o_seg  [NC];
    logic [1:0] o_dig  [NC];
    logic [8:0] o_oe   [NC];

    int checks = 0;
    int errors = 0;

    int         m_cnt [NC];
    int         m_pre [NC];
    bit         m_run [NC];
    bit         m_wrap [NC];
    logic [6:0] m_seg [NC];
    logic [1:0] m_dig [NC];
    int         m_t = 0;
    logic [3:0] smp [3];
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    bcd_counter_scan_disp #(.NUM_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .WRAP_EN(1), .SEG_ACT_LOW(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .cnt_start(cnt_start), .cnt_stop(cnt_stop), .cnt_rst(cnt_rst), .cnt_dir(cnt_dir),
        .cnt_bcd(o_cnt[0]), .running(o_run[0]), .wrap_o(o_wrap[0]), .disp_seg(o_seg[0]), .disp_dig(o_dig[0]), .out_en(o_oe[0]));

    bcd_counter_scan_disp #(.NUM_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .WRAP_EN(0), .SEG_ACT_LOW(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .cnt_start(cnt_start), .cnt_stop(cnt_stop), .cnt_rst(cnt_rst), .cnt_dir(cnt_dir),
        .cnt_bcd(o_cnt[1]), .running(o_run[1]), .wrap_o(o_wrap[1]), .disp_seg(o_seg[1]), .disp_dig(o_dig[1]), .out_en(o_oe[1]));

    bcd_counter_scan_disp #(.NUM_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .WRAP_EN(1), .SEG_ACT_LOW(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .cnt_start(cnt_start), .cnt_stop(cnt_stop), .cnt_rst(cnt_rst), .cnt_dir(cnt_dir),
        .cnt_bcd(o_cnt[2]), .running(o_run[2]), .wrap_o(o_wrap[2]), .disp_seg(o_seg[2]), .disp_dig(o_dig[2]), .out_en(o_oe[2]));

    // Reference model: count kept as an integer 0..99, pad actions land two edges after first sample
    always @(posedge clk) begin
        logic [3:0] rise;
        logic dir;
        int idx, dv;
        bit tick, term;
        if (!rst_n) begin
            for (int j = 0; j < 3; j++) smp[j] = '0;
            m_t = 0;
            for (int c = 0; c < NC; c++) begin
                m_cnt[c] = 0; m_pre[c] = 0; m_run[c] = 0; m_wrap[c] = 0;
                m_seg[c] = LOWS[c] != 0 ? 7'h7F : 7'h00;
                m_dig[c] = LOWS[c] != 0 ? 2'b11 : 2'b00;
            end
        end else begin
            rise = smp[1] & ~smp[2];
            dir  = smp[1][3];
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = {cnt_dir, cnt_rst, cnt_stop, cnt_start};
            idx = (m_t / 2) % 2;
            m_t++;
            for (int c = 0; c < NC; c++) begin
                dv = idx != 0 ? m_cnt[c] / 10 : m_cnt[c] % 10;
                m_seg[c] = seg_tab[dv] ^ (LOWS[c] != 0 ? 7'h7F : 7'h00);
                m_dig[c] = (idx != 0 ? 2'b10 : 2'b01) ^ (LOWS[c] != 0 ? 2'b11 : 2'b00);
                tick = m_run[c] && m_pre[c] == 3;
                term = dir ? m_cnt[c] == 0 : m_cnt[c] == 99;
                m_wrap[c] = 0;
                if (m_run[c]) m_pre[c] = (m_pre[c] + 1) % 4;
                if (rise[1]) m_run[c] = 0;
                else if (rise[0] && !m_run[c]) begin
                    m_run[c] = 1;
                    m_pre[c] = 0;
                end
                if (rise[2]) begin
                    m_cnt[c] = 0;
                    m_pre[c] = 0;
                end else if (tick) begin
                    m_wrap[c] = term;
                    if (term && WRAPS[c] == 0) m_run[c] = 0;
                    else m_cnt[c] = dir ? (m_cnt[c] + 99) % 100 : (m_cnt[c] + 1) % 100;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and compare every output of every instance to the model
    task automatic cycle();
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("cnt%0d", c),  32'(o_cnt[c]),  32'(((m_cnt[c] / 10) << 4) | (m_cnt[c] % 10)));
            chk($sformatf("run%0d", c),  32'(o_run[c]),  32'(m_run[c]));
            chk($sformatf("wrap%0d", c), 32'(o_wrap[c]), 32'(m_wrap[c]));
            chk($sformatf("seg%0d", c),  32'(o_seg[c]),  32'(m_seg[c]));
            chk($sformatf("dig%0d", c),  32'(o_dig[c]),  32'(m_dig[c]));
            chk($sformatf("oe%0d", c),   32'(o_oe[c]),   32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0; cnt_start = 1'b0; cnt_stop = 1'b0; cnt_rst = 1'b0; cnt_dir = 1'b0;
        repeat (3) cycle();
        chk("rst_cnt", 32'(o_cnt[0]), 32'h0);
        chk("rst_seg_lo", 32'(o_seg[2]), 32'h7F);
        chk("rst_dig_lo", 32'(o_dig[2]), 32'h3);
        chk("rst_seg_hi", 32'(o_seg[0]), 32'h0);
        rst_n = 1'b1;
        cnt_start = 1'b1; cycle(); cnt_start = 1'b0; cycle();
        chk("run_early", 32'(o_run[0]), 32'h0);
        cycle();
        chk("run_edge3", 32'(o_run[0]), 32'h1);
        repeat (3) cycle();
        chk("first_step_pre", 32'(o_cnt[0]), 32'h00);
        cycle();
        chk("first_step", 32'(o_cnt[0]), 32'h01);
        repeat (35) cycle();
        chk("cnt_09", 32'(o_cnt[0]), 32'h09);
        cycle();
        chk("carry_10", 32'(o_cnt[0]), 32'h10);
        repeat (356) cycle();
        chk("cnt_99_w", 32'(o_cnt[0]), 32'h99);
        chk("cnt_99_s", 32'(o_cnt[1]), 32'h99);
        repeat (4) cycle();
        chk("wrap_up_cnt", 32'(o_cnt[0]), 32'h00);
        chk("wrap_up_pulse", 32'(o_wrap[0]), 32'h1);
        chk("sat_hold", 32'(o_cnt[1]), 32'h99);
        chk("sat_pulse", 32'(o_wrap[1]), 32'h1);
        chk("sat_stop", 32'(o_run[1]), 32'h0);
        cnt_dir = 1'b1;
        repeat (4) cycle();
        chk("wrap_dn_cnt", 32'(o_cnt[0]), 32'h99);
        chk("wrap_dn_pulse", 32'(o_wrap[0]), 32'h1);
        repeat (356) cycle();
        chk("borrow_pre", 32'(o_cnt[0]), 32'h10);
        repeat (4) cycle();
        chk("borrow_09", 32'(o_cnt[0]), 32'h09);
        cnt_dir = 1'b0;
        repeat (4) cycle();
        cnt_start = 1'b1; cycle(); cnt_start = 1'b0;
        repeat (12) cycle();
        chk("sat_again_cnt", 32'(o_cnt[1]), 32'h99);
        chk("sat_again_run", 32'(o_run[1]), 32'h0);
        cnt_stop = 1'b1; cycle(); cnt_stop = 1'b0;
        repeat (4) cycle();
        chk("stopped", 32'(o_run[0]), 32'h0);
        cnt_start = 1'b1; cnt_stop = 1'b1; cycle(); cnt_start = 1'b0; cnt_stop = 1'b0;
        repeat (4) cycle();
        chk("stop_beats_start", 32'(o_run[0]), 32'h0);
        cnt_start = 1'b1; cycle(); cnt_start = 1'b0;
        repeat (9 + $urandom_range(0, 40)) cycle();
        cnt_rst = 1'b1; cycle(); cnt_rst = 1'b0;
        repeat (12) cycle();
        chk("rst_keeps_run", 32'(o_run[0]), 32'h1);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        chk("midrun_cnt", 32'(o_cnt[0]), 32'h0);
        chk("midrun_run", 32'(o_run[0]), 32'h0);
        chk("midrun_wrap", 32'(o_wrap[0]), 32'h0);
        for (int n = 0; n < 4000; n++) begin
            cnt_start = ($urandom_range(0, 19) == 0);
            cnt_stop  = ($urandom_range(0, 99) == 0);
            cnt_rst   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 99) == 0) cnt_dir = ~cnt_dir;
            rst_n = ($urandom_range(0, 999) != 0);
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter_scan_disp.md
Name: bcd_counter_scan_disp

Overview:
- Parametrised successor of the fixed-width counter top: an N-digit BCD up/down event counter with start/stop/clear pad controls.
- Adds a clock prescaler, wrap/saturate mode and a time-multiplexed seven-segment scan, so N digits share one 7-bit segment bus.
- Sits directly under user_project_wrapper, driven by wb_clk_i and user GPIO pads.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8).
- TICK_DIV, 1000, clk cycles per count step (>=2).
- SCAN_DIV, 256, clk cycles each digit stays enabled during scan (>=1).
- WRAP_EN, 1, 1 = roll over at terminal count; 0 = saturate and stop.
- SEG_ACT_LOW, 0, 1 = invert disp_seg and disp_dig polarity.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- cnt_start  in  1  async pad input, rising edge starts counting
- cnt_stop  in  1  async pad input, rising edge stops counting
- cnt_rst  in  1  async pad input, rising edge clears count
- cnt_dir  in  1  async pad level, 0 = up, 1 = down
- cnt_bcd  out  4*NUM_DIGITS  current count, digit 0 in LSBs
- running  out  1  1 while in RUN
- wrap_o  out  1  one-cycle pulse on rollover or saturation
- disp_seg  out  7  segments {g,f,e,d,c,b,a}, a = bit 0
- disp_dig  out  NUM_DIGITS  one-hot digit enable
- out_en  out  7+NUM_DIGITS  pad oeb, constant 0 (all outputs driven)

Behaviour:
- Reset (rst_n low at clk edge): count=0, state=STOP, prescaler=0, scan index=0, running=0, wrap_o=0, disp_seg=blank, disp_dig=none. Blank/none means all zeros, or all ones if SEG_ACT_LOW.
- Input conditioning:
  - Each of the four pad inputs passes through a 2-flop synchroniser plus a history flop.
  - rise = s2 & ~s3.
  - Input first sampled high at edge k -> action registered at edge k+2.
  - cnt_dir uses the synchronised level s2.
- FSM states: STOP, RUN.
  - STOP -> RUN on start_rise; prescaler cleared to 0.
  - RUN -> STOP on stop_rise.
  - Priority: stop beats start in the same cycle (state stays STOP, or goes STOP from RUN).
  - start_rise while in RUN is ignored; prescaler is not disturbed.
- rst_rise, any state: count=0 and prescaler=0; state unchanged.
  - rst_rise beats a coincident tick; no step occurs that cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; holds in STOP.
  - tick = (prescaler==TICK_DIV-1) in RUN.
- Step on tick:
  - Up: digit 9->0 with carry to the next digit.
  - Down: digit 0->9 with borrow to the next digit.
  - Terminal count: all 9s (up), all 0s (down).
  - At terminal count with WRAP_EN=1: rollover to all 0s (up) or all 9s (down); wrap_o=1 for one cycle.
  - At terminal count with WRAP_EN=0: count holds, state -> STOP, wrap_o=1 for one cycle.
- Display scan:
  - Scan timer counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, scan index advances, wrapping NUM_DIGITS-1 -> 0.
  - disp_seg and disp_dig are registered, showing the digit selected by the index one cycle earlier. First valid display is 1 cycle after reset release.
  - Digit values 10..15 are unreachable; decode them to blank.
  - Segment patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, active-high).
- cnt_bcd, running and wrap_o are registered; no combinational input-to-output paths.

Decomposition:
- Package bcd_disp_pkg holds:
  - state enum {STOP, RUN}
  - SEG_BLANK constant
  - 10-entry segment pattern constant array
  - function clog2 used for prescaler and scan widths
- Sub-module seg7_decode: combinational 4-bit BCD -> 7-bit pattern, polarity applied in the parent.
- Synchroniser is a generate loop in the parent, not a separate module.

Test Plan:
- Config for all scenarios: NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2, WRAP_EN=1.
- Basic up count: reset, pulse cnt_start -> running=1 at 3rd edge; cnt_bcd 0x00->0x01 after 4 more cycles, and 0x09->0x10 at the 10th tick.
- Up wrap / down borrow: preload via counting to 0x99, next tick -> 0x00 with a wrap_o pulse. Then set cnt_dir=1 at 0x00, next tick -> 0x99 with a wrap_o pulse; 0x10 -> 0x09.
- Saturate (WRAP_EN=0): count to 0x99, next tick -> holds 0x99, wrap_o pulse, running=0; later cnt_start resumes, next tick stays 0x99 and stops again.
- Priority: cnt_start and cnt_stop rising together -> running stays 0. cnt_rst during RUN at 0x37 -> 0x00, running stays 1, next step exactly TICK_DIV cycles later.
- Scan: cnt_bcd=0x42 -> disp_dig alternates 01/10 every 2 cycles with disp_seg 5B/66. With SEG_ACT_LOW=1 both are inverted: disp_dig 10/01, disp_seg 24/19.
- Reset mid-run: rst_n low for 1 edge at count 0x55 -> all outputs at reset values next cycle; no wrap_o glitch.
